fp16_align_acc: RTL and testbench
=================================

FP16_ALIGN_ACC -- requirements
Module: fp16_align_acc

Interface
REQ-001 Parameter N_TERMS, default 4, terms per accumulation group; legal range 2..8.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_valid  input  1  input term valid.
REQ-005 o_ready  output  1  block accepts a term this cycle.
REQ-006 i_sign  input  1  term sign, 1 = negative.
REQ-007 i_exp  input  5  term biased exponent.
REQ-008 i_mant  input  11  term mantissa with explicit leading one at bit 10; 0 = zero term.
REQ-009 o_valid  output  1  group result valid.
REQ-010 i_ready  input  1  downstream normalizer accepts the result.
REQ-011 o_sum  output  19  two's-complement aligned group sum, leading-one reference at bit 13, bits 2:0 guard/round/sticky extension.
REQ-012 o_max_exp  output  5  group reference exponent that o_sum is scaled to.

Function
REQ-013 States SHALL be COLLECT, ALIGN, DONE; o_ready = 1 only in COLLECT.
REQ-014 COLLECT: each i_valid&o_ready cycle SHALL store {sign,exp,mant} into buffer slot k (k = 0..N_TERMS-1) and increment k.
REQ-015 The running max exponent SHALL be updated only by terms with i_mant != 0; zero terms never set the max.
REQ-016 On acceptance of term N_TERMS-1, the state SHALL go to ALIGN with k = 0, accumulator = 0.
REQ-017 ALIGN SHALL process one buffered term per cycle: shift = max_exp - exp (0..31); magnitude = ({mant,3'b000} >> shift), with bit 0 ORed with the OR of all shifted-out bits.
REQ-018 shift >= 14 with mant != 0 SHALL yield magnitude = 1 (sticky only); mant = 0 SHALL yield 0 regardless of shift.
REQ-019 Magnitude SHALL be zero-extended to 19 bits, negated (two's complement) when sign = 1, and added to the 19-bit accumulator; the sum SHALL never overflow for N_TERMS <= 8.
REQ-020 After the last ALIGN cycle the state SHALL go to DONE with o_valid = 1; latency from the last input handshake to o_valid = N_TERMS + 1 cycles.
REQ-021 In DONE, o_sum and o_max_exp SHALL be held stable until o_valid & i_ready, then the state SHALL return to COLLECT with k = 0 and max = 0 on the next cycle.
REQ-022 A group of all zero terms SHALL produce o_sum = 0, o_max_exp = 0.
REQ-023 An i_valid while o_ready = 0 SHALL be ignored; the source holds the term until the handshake.
REQ-024 The block SHALL NOT round; rounding is done downstream from bits 2:0.

Reset
REQ-025 When i_rst_n = 0 at a clock edge: state = COLLECT, k = 0, max = 0, accumulator = 0, o_valid = 0, o_sum = 0, o_max_exp = 0, o_ready = 1 on the following cycle.
REQ-026 Reset asserted in any state, including mid-ALIGN or DONE, SHALL discard the partial group with no output.

Structure
REQ-027 Shared package SHALL hold SUM_W = 19, EXP_W = 5, MANT_W = 11, EXT_W = 3, LEAD_POS = 13 and the state enumeration.
REQ-028 One combinational sub-module align_shifter SHALL implement shift, sticky and conditional negation (REQ-017..019); FSM, buffer and accumulator stay in the top.

Verification
REQ-029 Four terms exp=15, mant=0x400, sign=0 -> o_sum = 0x08000, o_max_exp = 15, o_valid 5 cycles after the 4th handshake.
REQ-030 {+,15,0x400}, {-,15,0x400}, two zero terms -> o_sum = 0, o_max_exp = 15.
REQ-031 {+,16,0x600}, {+,15,0x400}, two zero terms -> o_sum = 0x04000 (0x3000 + 0x1000), o_max_exp = 16.
REQ-032 {+,20,0x400}, {+,3,0x7FF}, two zero terms -> shift 17 is sticky only: o_sum = 0x02001, o_max_exp = 20.
REQ-033 i_ready held low for 5 cycles in DONE -> o_sum and o_valid stable and o_ready = 0 throughout; i_rst_n = 0 during ALIGN -> o_valid never rises, and the next group of four 0x400@15 terms returns 0x08000.

Source files
------------

// File: rtl/fp16_align_acc_pkg.sv
// fp16_align_acc_pkg
// Shared widths, the controller state encoding and the buffered-term record
// for the FP16 alignment accumulator.
package fp16_align_acc_pkg;

  localparam int SUM_W    = 19;             // accumulator / result width
  localparam int EXP_W    = 5;              // biased exponent width
  localparam int MANT_W   = 11;             // mantissa incl. explicit leading one
  localparam int EXT_W    = 3;              // guard/round/sticky extension
  localparam int LEAD_POS = 13;             // leading-one position in the aligned magnitude
  localparam int MAG_W    = LEAD_POS + 1;   // aligned magnitude width

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ALIGN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } term_t;

endpackage

// File: rtl/fp16_align_acc_align_shifter.sv
// fp16_align_acc_align_shifter
// Combinational alignment of one buffered term to the group exponent.
// Right-shifts {mant,GRS} by (max_exp - exp), folds every shifted-out bit
// into bit 0 as sticky, and returns the signed 19-bit addend.
// Ports:
//   max_exp - group reference exponent
//   term    - buffered {sign, exp, mant}
//   addend  - two's-complement aligned term, zero-extended to SUM_W
module fp16_align_acc_align_shifter
  import fp16_align_acc_pkg::*;
(
  input  logic [EXP_W-1:0] max_exp,
  input  term_t            term,
  output logic [SUM_W-1:0] addend
);

  logic [EXP_W-1:0] shift_s;
  logic [MAG_W-1:0] ext_s;
  logic [MAG_W-1:0] mask_s;
  logic [MAG_W-1:0] mag_s;
  logic             sticky_s;

  // Shift, sticky collapse and conditional negation of one term
  always_comb begin
    shift_s  = max_exp - term.exp;
    ext_s    = {term.mant, {EXT_W{1'b0}}};
    mask_s   = '0;
    sticky_s = 1'b0;
    mag_s    = '0;
    if (term.mant == '0) begin
      // A zero term may carry any exponent, so the wrapped shift is irrelevant.
      mag_s = '0;
    end else if (shift_s >= EXP_W'(MAG_W)) begin
      // Every significant bit falls off the end: only sticky survives.
      mag_s = MAG_W'(1);
    end else begin
      mask_s   = (MAG_W'(1) << shift_s) - MAG_W'(1);
      sticky_s = |(ext_s & mask_s);
      mag_s    = (ext_s >> shift_s) | {{(MAG_W-1){1'b0}}, sticky_s};
    end
    if (term.sign) begin
      addend = ~{{(SUM_W-MAG_W){1'b0}}, mag_s} + SUM_W'(1);
    end else begin
      addend = {{(SUM_W-MAG_W){1'b0}}, mag_s};
    end
  end

endmodule

// File: rtl/fp16_align_acc.sv
// fp16_align_acc
// Collects N_TERMS FP16 terms, tracks the largest exponent of the nonzero
// terms, then aligns and sums one buffered term per cycle into a 19-bit
// two's-complement result (leading one at bit 13, GRS in bits 2:0).
// No rounding is done here.
// Ports:
//   i_clk, i_rst_n             - clock, synchronous active-low reset
//   i_valid/o_ready            - input term handshake (ready only in COLLECT)
//   i_sign, i_exp, i_mant      - input term
//   o_valid/i_ready            - result handshake
//   o_sum, o_max_exp           - aligned group sum and its reference exponent
module fp16_align_acc
  import fp16_align_acc_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [SUM_W-1:0]  o_sum,
  output logic [EXP_W-1:0]  o_max_exp
);

  // k has to reach N_TERMS: that extra ALIGN step publishes the finished sum.
  localparam int K_W = $clog2(N_TERMS + 1);

  state_t           state_r;
  logic [K_W-1:0]   k_r;
  logic [EXP_W-1:0] max_r;
  logic [SUM_W-1:0] acc_r;
  term_t            buf_r [N_TERMS];
  logic             ready_r;
  logic             valid_r;
  logic [SUM_W-1:0] sum_r;
  logic [EXP_W-1:0] max_out_r;
  term_t            cur_s;
  logic [SUM_W-1:0] addend_s;

  assign o_ready   = ready_r;
  assign o_valid   = valid_r;
  assign o_sum     = sum_r;
  assign o_max_exp = max_out_r;

  // Select the buffered term addressed by k; the publish step sees a zero term
  always_comb begin
    cur_s = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (k_r == K_W'(i)) begin
        cur_s = buf_r[i];
      end else begin
        cur_s = cur_s;
      end
    end
  end

  fp16_align_acc_align_shifter u_align_shifter (
    .max_exp (max_r),
    .term    (cur_s),
    .addend  (addend_s)
  );

  // Controller FSM, term buffer, running max, accumulator and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= COLLECT;
      k_r       <= '0;
      max_r     <= '0;
      acc_r     <= '0;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      sum_r     <= '0;
      max_out_r <= '0;
      for (int i = 0; i < N_TERMS; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      case (state_r)
        COLLECT: begin
          if (i_valid && ready_r) begin
            for (int i = 0; i < N_TERMS; i++) begin
              if (k_r == K_W'(i)) begin
                buf_r[i] <= {i_sign, i_exp, i_mant};
              end
            end
            // Zero terms carry no magnitude and must not pull the reference up.
            if ((i_mant != '0) && (i_exp > max_r)) begin
              max_r <= i_exp;
            end
            if (k_r == K_W'(N_TERMS - 1)) begin
              state_r <= ALIGN;
              k_r     <= '0;
              acc_r   <= '0;
              ready_r <= 1'b0;
            end else begin
              k_r <= k_r + K_W'(1);
            end
          end
        end
        ALIGN: begin
          if (k_r == K_W'(N_TERMS)) begin
            sum_r     <= acc_r;
            max_out_r <= max_r;
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end else begin
            acc_r <= acc_r + addend_s;
            k_r   <= k_r + K_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= COLLECT;
            k_r     <= '0;
            max_r   <= '0;
            acc_r   <= '0;
          end
        end
        default: begin
          state_r <= COLLECT;
          k_r     <= '0;
          max_r   <= '0;
          acc_r   <= '0;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_align_acc.sv
// tb_fp16_align_acc
// Directed self-checking bench for fp16_align_acc (N_TERMS = 4).
// Terms are written as 17-bit {sign, exp[4:0], mant[10:0]}.
module tb_fp16_align_acc;
  import fp16_align_acc_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [4:0]  i_exp;
  logic [10:0] i_mant;
  logic        o_valid;
  logic        i_ready;
  logic [18:0] o_sum;
  logic [4:0]  o_max_exp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [16:0] T_ONE  = {1'b0, 5'd15, 11'h400};
  localparam logic [16:0] T_ZERO = {1'b0, 5'd0,  11'h000};

  fp16_align_acc #(.N_TERMS(4)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_sign    (i_sign),
    .i_exp     (i_exp),
    .i_mant    (i_mant),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
    .o_max_exp (o_max_exp)
  );

  always #5 i_clk = ~i_clk;

  // Present one term and hold it until the handshake edge.
  task automatic send_term(input logic [16:0] t);
    int cnt;
    i_valid = 1'b1;
    {i_sign, i_exp, i_mant} = t;
    cnt = 0;
    while (o_ready !== 1'b1 && cnt < 50) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    if (cnt >= 50) begin
      total_cnt++;
      $display("FAIL send_timeout: o_ready=%b after %0d cycles, need 1", o_ready, cnt);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  // Send four terms, then count cycles from the last handshake to o_valid.
  task automatic run_group(input logic [16:0] t0, input logic [16:0] t1,
                           input logic [16:0] t2, input logic [16:0] t3,
                           output logic [18:0] sum, output logic [4:0] mexp,
                           output int lat);
    send_term(t0);
    send_term(t1);
    send_term(t2);
    send_term(t3);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    sum  = o_sum;
    mexp = o_max_exp;
  endtask

  task automatic accept_result();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    {i_sign, i_exp, i_mant} = '0;
    repeat (2) @(posedge i_clk);
    #1;
    total_cnt++;
    if ({o_ready, o_valid, o_sum, o_max_exp} !== {1'b1, 1'b0, 19'h0, 5'd0}) begin
      $display("FAIL reset: ready=%b valid=%b sum=%h exp=%0d, need 1 0 00000 0",
               o_ready, o_valid, o_sum, o_max_exp);
    end else pass_cnt++;
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [18:0] s; logic [4:0] e; int lat;
    run_group(T_ONE, T_ONE, T_ONE, T_ONE, s, e, lat);
    total_cnt++;
    if (s !== 19'h08000) $display("FAIL basic_sum: got %h need 08000", s);
    else pass_cnt++;
    total_cnt++;
    if (e !== 5'd15) $display("FAIL basic_exp: got %0d need 15", e);
    else pass_cnt++;
    total_cnt++;
    if (lat != 5) $display("FAIL basic_latency: got %0d need 5", lat);
    else pass_cnt++;
    accept_result();
    total_cnt++;
    if ({o_valid, o_ready} !== 2'b01) $display("FAIL basic_release: valid/ready=%b need 01", {o_valid, o_ready});
    else pass_cnt++;
  endtask

  task automatic test_cancel();
    logic [18:0] s; logic [4:0] e; int lat;
    run_group(T_ONE, {1'b1, 5'd15, 11'h400}, T_ZERO, T_ZERO, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h0, 5'd15}) $display("FAIL cancel: sum=%h exp=%0d need 00000 15", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_align();
    logic [18:0] s; logic [4:0] e; int lat;
    run_group({1'b0, 5'd16, 11'h600}, T_ONE, T_ZERO, T_ZERO, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h04000, 5'd16}) $display("FAIL align: sum=%h exp=%0d need 04000 16", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_sticky();
    logic [18:0] s; logic [4:0] e; int lat;
    // Shift 17: only the sticky bit remains.
    run_group({1'b0, 5'd20, 11'h400}, {1'b0, 5'd3, 11'h7FF}, T_ZERO, T_ZERO, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h02001, 5'd20}) $display("FAIL sticky_far: sum=%h exp=%0d need 02001 20", s, e);
    else pass_cnt++;
    accept_result();
    // Shift 4 of 0x2008: 0x200 kept, bit 3 lost -> sticky -> 0x201.
    run_group(T_ONE, {1'b0, 5'd11, 11'h401}, T_ZERO, T_ZERO, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h02201, 5'd15}) $display("FAIL sticky_near: sum=%h exp=%0d need 02201 15", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_negative();
    logic [18:0] s; logic [4:0] e; int lat;
    // -0x2000 + 0x1000 = -0x1000
    run_group({1'b1, 5'd15, 11'h400}, {1'b0, 5'd14, 11'h400}, T_ZERO, T_ZERO, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h7F000, 5'd15}) $display("FAIL negative: sum=%h exp=%0d need 7f000 15", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_zero_group();
    logic [18:0] s; logic [4:0] e; int lat;
    // Zero terms with large exponents must not set the reference.
    run_group({1'b0, 5'd10, 11'h0}, {1'b1, 5'd30, 11'h0}, T_ZERO, {1'b0, 5'd7, 11'h0}, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h0, 5'd0}) $display("FAIL zero_group: sum=%h exp=%0d need 00000 0", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_backpressure();
    logic [18:0] s; logic [4:0] e; int lat;
    run_group(T_ONE, T_ONE, T_ONE, T_ONE, s, e, lat);
    // Offer a junk term while the result is stalled; it must be ignored.
    i_valid = 1'b1;
    {i_sign, i_exp, i_mant} = {1'b0, 5'd30, 11'h7FF};
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk); #1;
      total_cnt++;
      if ({o_valid, o_ready, o_sum} !== {1'b1, 1'b0, 19'h08000}) begin
        $display("FAIL stall_cycle%0d: valid=%b ready=%b sum=%h need 1 0 08000",
                 c, o_valid, o_ready, o_sum);
      end else pass_cnt++;
    end
    i_valid = 1'b0;
    accept_result();
    run_group(T_ONE, T_ONE, T_ONE, T_ONE, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h08000, 5'd15}) $display("FAIL after_stall: sum=%h exp=%0d need 08000 15", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  task automatic test_reset_mid_align();
    logic [18:0] s; logic [4:0] e; int lat;
    bit seen;
    send_term({1'b0, 5'd20, 11'h7FF});
    send_term(T_ONE);
    send_term(T_ONE);
    send_term(T_ONE);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    total_cnt++;
    if ({o_ready, o_valid} !== 2'b10) $display("FAIL mid_reset_state: ready/valid=%b need 10", {o_ready, o_valid});
    else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_reset_valid: o_valid rose %b need 0", seen);
    else pass_cnt++;
    run_group(T_ONE, T_ONE, T_ONE, T_ONE, s, e, lat);
    total_cnt++;
    if ({s, e} !== {19'h08000, 5'd15}) $display("FAIL after_reset: sum=%h exp=%0d need 08000 15", s, e);
    else pass_cnt++;
    accept_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_align();
    test_sticky();
    test_negative();
    test_zero_group();
    test_backpressure();
    test_reset_mid_align();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
